// File: rtl/dvb_pls_dec_bit6_ctrl_pkg.sv
// Shared types and constants for the DVB PLS bit-6 decoder controller.
// Soft symbols are signed bytes; bit-6 metrics are signed 16-bit sums.
package dvb_pls_dec_bit6_ctrl_pkg;

  localparam int PLS_SYM_NUM  = 64;
  localparam int SYM_CNT_W    = 6;
  localparam int METRIC_W     = 8;
  localparam int METRIC_SUM_W = 16;
  localparam int WAIT_CYC     = 3;

  typedef logic signed [METRIC_W-1:0]     metric_t;
  typedef logic signed [METRIC_SUM_W-1:0] metric_sum_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Magnitude of a soft symbol, widened so that -128 stays representable.
  function automatic metric_sum_t metric_abs(input metric_t d);
    metric_sum_t w;
    w = metric_sum_t'(d);
    return w[METRIC_SUM_W-1] ? -w : w;
  endfunction

endpackage

// File: rtl/dvb_pls_dec_bit6_ctrl_dec.sv
// Bit-6 accumulator: sums symbol magnitudes into an add and a sub bucket and
// emits (sub - add) with a one-cycle strobe on the last symbol of the header.
module dvb_pls_dec_bit6_dec
  import dvb_pls_dec_bit6_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clkena,
  input  logic        val,
  input  logic        sop,
  input  logic        eop,
  input  logic        add_n_sub,
  input  metric_t     dat,
  output logic        metric_val,
  output metric_sum_t metric
);

  metric_sum_t add_sum_r;
  metric_sum_t sub_sum_r;
  metric_sum_t metric_r;
  logic        metric_val_r;
  metric_sum_t mag_s;
  metric_sum_t add_nxt_s;
  metric_sum_t sub_nxt_s;

  // Next bucket values; sop restarts whichever bucket this symbol targets.
  always_comb begin
    mag_s     = metric_abs(dat);
    add_nxt_s = add_sum_r;
    sub_nxt_s = sub_sum_r;
    if (add_n_sub) begin
      add_nxt_s = (sop ? '0 : add_sum_r) + mag_s;
    end else begin
      sub_nxt_s = (sop ? '0 : sub_sum_r) + mag_s;
    end
  end

  // Accumulator and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      add_sum_r    <= '0;
      sub_sum_r    <= '0;
      metric_r     <= '0;
      metric_val_r <= 1'b0;
    end else if (clkena) begin
      metric_val_r <= 1'b0;
      if (val) begin
        if (add_n_sub) begin
          add_sum_r <= add_nxt_s;
        end else begin
          sub_sum_r <= sub_nxt_s;
        end
        if (eop) begin
          metric_r     <= sub_nxt_s - add_nxt_s;
          metric_val_r <= 1'b1;
        end
      end
    end
  end

  assign metric_val = metric_val_r;
  assign metric     = metric_r;

endmodule

// File: rtl/dvb_pls_dec_bit6_ctrl.sv
// Frame controller for PLS bit-6 decoding: tracks the 64-symbol header,
// drives the accumulator with per-symbol add/sub steering, reports result or error.
module dvb_pls_dec_bit6_ctrl
  import dvb_pls_dec_bit6_ctrl_pkg::*;
(
  input  logic        iclk,
  input  logic        ireset_n,
  input  logic        iclkena,
  input  logic        isop,
  input  logic        ival,
  input  logic        ieop,
  input  metric_t     idat,
  output logic        ordy,
  output logic        oval,
  output logic        obit6,
  output metric_sum_t ometric,
  output logic        oerr
);

  localparam logic [SYM_CNT_W-1:0] SYM_LAST  = SYM_CNT_W'(PLS_SYM_NUM - 1);
  localparam logic [1:0]           WAIT_LAST = 2'(WAIT_CYC - 1);

  state_t                 state_r;
  state_t                 state_nxt;
  logic [SYM_CNT_W-1:0]   sym_cnt_r;
  logic [SYM_CNT_W-1:0]   sym_cnt_nxt;
  logic [1:0]             wait_cnt_r;
  logic [1:0]             wait_cnt_nxt;

  logic                   drv_val_s;
  logic                   drv_sop_s;
  logic                   drv_eop_s;
  logic [SYM_CNT_W-1:0]   drv_k_s;
  logic                   err_s;

  logic                   dec_val_r;
  logic                   dec_sop_r;
  logic                   dec_eop_r;
  logic                   dec_add_n_sub_r;
  metric_t                dec_dat_r;
  logic                   dec_metric_val_s;
  metric_sum_t            dec_metric_s;

  metric_sum_t            metric_lat_r;
  logic                   ordy_r;
  logic                   oval_r;
  logic                   oerr_r;
  logic                   obit6_r;
  metric_sum_t            ometric_r;

  // Next-state and decoder-drive decode; drv_k_s is the index of the accepted symbol.
  always_comb begin
    state_nxt    = state_r;
    sym_cnt_nxt  = sym_cnt_r;
    wait_cnt_nxt = wait_cnt_r;
    drv_val_s    = 1'b0;
    drv_eop_s    = 1'b0;
    drv_k_s      = sym_cnt_r;
    err_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ival && isop) begin
          state_nxt   = ST_RUN;
          sym_cnt_nxt = SYM_CNT_W'(1);
          drv_val_s   = 1'b1;
          drv_k_s     = '0;
        end else begin
          state_nxt   = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (ival) begin
          if (isop) begin
            err_s       = 1'b1;
            sym_cnt_nxt = SYM_CNT_W'(1);
            drv_val_s   = 1'b1;
            drv_k_s     = '0;
          end else if (ieop) begin
            if (sym_cnt_r == SYM_LAST) begin
              state_nxt    = ST_WAIT;
              wait_cnt_nxt = 2'd0;
              drv_val_s    = 1'b1;
              drv_eop_s    = 1'b1;
            end else begin
              err_s       = 1'b1;
              state_nxt   = ST_IDLE;
              sym_cnt_nxt = '0;
            end
          end else if (sym_cnt_r == SYM_LAST) begin
            // Index 63 without eop: the count never wraps, the frame is dropped.
            err_s       = 1'b1;
            state_nxt   = ST_IDLE;
            sym_cnt_nxt = '0;
          end else begin
            sym_cnt_nxt = sym_cnt_r + SYM_CNT_W'(1);
            drv_val_s   = 1'b1;
          end
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_r == WAIT_LAST) begin
          state_nxt = ST_DONE;
        end else begin
          wait_cnt_nxt = wait_cnt_r + 2'd1;
        end
      end
      ST_DONE: begin
        state_nxt   = ST_IDLE;
        sym_cnt_nxt = '0;
      end
      default: begin
        state_nxt   = ST_IDLE;
        sym_cnt_nxt = '0;
      end
    endcase
    drv_sop_s = drv_val_s && (drv_k_s <= SYM_CNT_W'(1));
  end

  // FSM state, counters and the registered decoder drive.
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      state_r         <= ST_IDLE;
      sym_cnt_r       <= '0;
      wait_cnt_r      <= 2'd0;
      dec_val_r       <= 1'b0;
      dec_sop_r       <= 1'b0;
      dec_eop_r       <= 1'b0;
      dec_add_n_sub_r <= 1'b0;
      dec_dat_r       <= '0;
    end else if (iclkena) begin
      state_r         <= state_nxt;
      sym_cnt_r       <= sym_cnt_nxt;
      wait_cnt_r      <= wait_cnt_nxt;
      dec_val_r       <= drv_val_s;
      dec_sop_r       <= drv_sop_s;
      dec_eop_r       <= drv_eop_s;
      dec_add_n_sub_r <= ~drv_k_s[0];
      dec_dat_r       <= idat;
    end
  end

  // Output registers; the metric is latched on the decoder strobe and published from DONE.
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      metric_lat_r <= '0;
      ordy_r       <= 1'b1;
      oval_r       <= 1'b0;
      oerr_r       <= 1'b0;
      obit6_r      <= 1'b0;
      ometric_r    <= '0;
    end else if (iclkena) begin
      ordy_r <= (state_nxt == ST_IDLE) || (state_nxt == ST_RUN);
      oerr_r <= err_s;
      oval_r <= (state_r == ST_DONE);
      if (dec_metric_val_s) begin
        metric_lat_r <= dec_metric_s;
      end
      if (state_r == ST_DONE) begin
        ometric_r <= metric_lat_r;
        obit6_r   <= !metric_lat_r[METRIC_SUM_W-1] && (metric_lat_r != '0);
      end
    end
  end

  dvb_pls_dec_bit6_dec u_dec (
    .clk        (iclk),
    .reset      (~ireset_n),
    .clkena     (iclkena),
    .val        (dec_val_r),
    .sop        (dec_sop_r),
    .eop        (dec_eop_r),
    .add_n_sub  (dec_add_n_sub_r),
    .dat        (dec_dat_r),
    .metric_val (dec_metric_val_s),
    .metric     (dec_metric_s)
  );

  assign ordy    = ordy_r;
  assign oval    = oval_r;
  assign oerr    = oerr_r;
  assign obit6   = obit6_r;
  assign ometric = ometric_r;

endmodule
